muldiv_sequencer: RTL

- Multi-cycle multiply/divide engine and sequencer that owns the HI/LO result path of the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU operands from the register file and iterates one bit per cycle.
- Stalls the core while busy, then pulses a single write strobe into the HI and LO registers.
- Replaces the combinational HI/LO generation in the ALU, removing that logic from the critical path.

---
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO write path; one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             hilo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   rs_r, rt_r;
  logic [2*WIDTH-1:0] acc, opnd_a;
  logic [WIDTH-1:0]   opnd_b;
  logic [CW-1:0]      count;
  logic               neg_q, neg_r, div0;

  logic               is_div, signed_op, ge, last_iter;
  logic [WIDTH-1:0]   rs_abs, rt_abs, diff;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] mul_sum;

  assign is_div    = op_r[1];
  assign signed_op = ~op_r[0];
  assign rs_abs    = (signed_op && rs_r[WIDTH-1]) ? -rs_r : rs_r;
  assign rt_abs    = (signed_op && rt_r[WIDTH-1]) ? -rt_r : rt_r;

  // Restoring step: partial remainder with the next dividend bit shifted in
  assign partial = acc[2*WIDTH-1:WIDTH-1];
  assign ge      = partial >= {1'b0, opnd_a[WIDTH-1:0]};
  assign diff    = partial[WIDTH-1:0] - opnd_a[WIDTH-1:0];
  assign mul_sum = acc + opnd_a;

  always_comb begin
    last_iter = (count == CW'(1));
`ifdef MULDIV_EARLY_OUT_EN
    if (!is_div && (opnd_b[WIDTH-1:1] == '0))
      last_iter = 1'b1;
`endif
  end

  assign stall      = start | busy;
  assign hilo_write = done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      count  <= '0;
      op_r   <= '0;
      rs_r   <= '0;
      rt_r   <= '0;
      acc    <= '0;
      opnd_a <= '0;
      opnd_b <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= op;
            rs_r  <= rs_val;
            rt_r  <= rt_val;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          neg_q <= signed_op & (rs_r[WIDTH-1] ^ rt_r[WIDTH-1]);
          neg_r <= signed_op & rs_r[WIDTH-1];
          div0  <= is_div && (rt_r == '0);
          count <= CW'(WIDTH);
          if (is_div) begin
            acc    <= {{WIDTH{1'b0}}, rs_abs};
            opnd_a <= {{WIDTH{1'b0}}, rt_abs};
          end else begin
            acc    <= '0;
            opnd_a <= {{WIDTH{1'b0}}, rs_abs};
          end
          opnd_b <= rt_abs;
          state  <= RUN;
        end
        RUN: begin
          count <= count - CW'(1);
          if (is_div) begin
            if (ge) acc <= {diff, acc[WIDTH-2:0], 1'b1};
            else    acc <= {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else begin
            if (opnd_b[0]) acc <= mul_sum;
            opnd_a <= opnd_a << 1;
            opnd_b <= opnd_b >> 1;
          end
          if (last_iter) state <= FIX;
        end
        FIX: begin
          // Divide-by-zero returns the raw dividend in HI whatever the signedness
          if (div0) begin
            hi_out <= rs_r;
            lo_out <= '1;
          end else if (is_div) begin
            hi_out <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo_out <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          end else begin
            {hi_out, lo_out} <= neg_q ? -acc : acc;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
